// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
//
// Launches one SPI transfer per audio frame period. At each frame tick the
// pending DAC sample is packed behind a constant command header and the SPI
// controller is strobed with spi_cs. The received word's low bits are presented
// on a valid/ready ADC stream once the transfer completes. Sticky status flags
// record underrun, overrun, missed ticks and (optionally) transfer timeouts.
//
// Ports:
//   clk, nrst               clock; synchronous active-low reset
//   spi_cs                  active-low frame start strobe to the SPI controller
//   spi_tx_data             {TX_CMD, sample} word held from launch to launch
//   spi_rx_data, spi_done   received word and controller idle flag (1 = idle)
//   dac_sample/valid/ready  incoming sample stream
//   adc_sample/valid/ready  outgoing captured sample stream
//   status_clr              clears sticky flags (a same-cycle set wins)
//   status                  sticky {timeout, miss, overrun, underrun}
//
// Optional feature: define SEQ_TIMEOUT_EN to compile the transfer watchdog.
// Without it the sequencer waits indefinitely and status[3] is always 0.
// Assumes TX_WIDTH > SAMPLE_WIDTH and RX_WIDTH >= SAMPLE_WIDTH.

module spi_frame_sequencer #(
    parameter int unsigned                        CLK_PER_SAMPLE = 1000,
    parameter int unsigned                        TX_WIDTH       = 24,
    parameter int unsigned                        RX_WIDTH       = 24,
    parameter int unsigned                        SAMPLE_WIDTH   = 16,
    parameter logic [TX_WIDTH-SAMPLE_WIDTH-1:0]   TX_CMD         = 8'h30,
    parameter int unsigned                        CS_LOW_CYCLES  = 2,
    parameter int unsigned                        TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    nrst,
    output logic                    spi_cs,
    output logic [TX_WIDTH-1:0]     spi_tx_data,
    input  logic [RX_WIDTH-1:0]     spi_rx_data,
    input  logic                    spi_done,
    input  logic [SAMPLE_WIDTH-1:0] dac_sample,
    input  logic                    dac_valid,
    output logic                    dac_ready,
    output logic [SAMPLE_WIDTH-1:0] adc_sample,
    output logic                    adc_valid,
    input  logic                    adc_ready,
    input  logic                    status_clr,
    output logic [3:0]              status
);

    localparam int unsigned CntW = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam int unsigned CsW  = $clog2(CS_LOW_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCsLow,
        StWaitStart,
        StWaitEnd,
        StSettle,
        StCapture
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [CsW-1:0]          cs_cnt_q, cs_cnt_d;
    logic [TX_WIDTH-1:0]     tx_q, tx_d;
    logic [SAMPLE_WIDTH-1:0] dac_hold_q, dac_hold_d;
    logic                    dac_pending_q, dac_pending_d;
    logic [SAMPLE_WIDTH-1:0] adc_sample_q, adc_sample_d;
    logic                    adc_valid_q, adc_valid_d;
    logic [3:0]              status_q, status_d;

    logic tick;
    logic launch;
    logic miss;
    logic dac_load;
    logic capture;
    logic overrun;
    logic underrun;
    logic cs_done;
    logic timeout_hit;

    // Frame timing and the events derived from it.
    assign tick     = (cnt_q == CntW'(CLK_PER_SAMPLE - 1));
    assign cnt_d    = tick ? '0 : cnt_q + 1'b1;
    assign launch   = tick && (state_q == StIdle) && spi_done;
    assign miss     = tick && !launch;
    assign dac_load = dac_valid && !dac_pending_q;
    assign capture  = (state_q == StCapture);
    assign cs_done  = (cs_cnt_q == CsW'(CS_LOW_CYCLES - 1));
    assign cs_cnt_d = (state_q == StCsLow) ? cs_cnt_q + 1'b1 : '0;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           in_wait;

    // Counts total cycles spent waiting on the controller for one frame.
    assign in_wait     = (state_q == StWaitStart) || (state_q == StWaitEnd);
    assign wd_d        = in_wait ? wd_q + 1'b1 : '0;
    assign timeout_hit = in_wait && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    if (RX_WIDTH > SAMPLE_WIDTH) begin : g_rx_unused
        logic unused_rx_bits;
        assign unused_rx_bits = ^spi_rx_data[RX_WIDTH-1:SAMPLE_WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the watchdog overrides the wait transitions.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (launch) state_d = StCsLow;
            end
            StCsLow: begin
                if (cs_done) state_d = StWaitStart;
            end
            StWaitStart: begin
                if (timeout_hit)   state_d = StIdle;
                else if (!spi_done) state_d = StWaitEnd;
            end
            StWaitEnd: begin
                if (timeout_hit)  state_d = StIdle;
                else if (spi_done) state_d = StSettle;
            end
            StSettle:  state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        spi_cs      = (state_q != StCsLow);
        dac_ready   = !dac_pending_q;
        spi_tx_data = tx_q;
        adc_sample  = adc_sample_q;
        adc_valid   = adc_valid_q;
        status      = status_q;
    end

    // Datapath next-state.
    always_comb begin
        tx_d          = tx_q;
        dac_hold_d    = dac_hold_q;
        dac_pending_d = dac_pending_q;
        adc_sample_d  = adc_sample_q;
        adc_valid_d   = adc_valid_q;

        // Launch sends the current hold; with nothing pending this repeats the
        // previous sample.
        if (launch) begin
            tx_d          = {TX_CMD, dac_hold_q};
            dac_pending_d = 1'b0;
        end
        // A load in the launch cycle only happens when nothing was pending, so
        // the new sample is kept for the next frame rather than dropped.
        if (dac_load) begin
            dac_hold_d    = dac_sample;
            dac_pending_d = 1'b1;
        end

        if (capture) begin
            adc_sample_d = spi_rx_data[SAMPLE_WIDTH-1:0];
            adc_valid_d  = 1'b1;
        end else if (adc_valid_q && adc_ready) begin
            adc_valid_d = 1'b0;
        end

        overrun  = capture && adc_valid_q && !adc_ready;
        underrun = launch && !dac_pending_q;
        status_d = (status_clr ? 4'b0000 : status_q) | {timeout_hit, miss, overrun, underrun};
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q         <= '0;
            cs_cnt_q      <= '0;
            tx_q          <= {TX_CMD, {SAMPLE_WIDTH{1'b0}}};
            dac_hold_q    <= '0;
            dac_pending_q <= 1'b0;
            adc_sample_q  <= '0;
            adc_valid_q   <= 1'b0;
            status_q      <= 4'b0000;
        end else begin
            cnt_q         <= cnt_d;
            cs_cnt_q      <= cs_cnt_d;
            tx_q          <= tx_d;
            dac_hold_q    <= dac_hold_d;
            dac_pending_q <= dac_pending_d;
            adc_sample_q  <= adc_sample_d;
            adc_valid_q   <= adc_valid_d;
            status_q      <= status_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Testbench for spi_frame_sequencer: an SPI controller model drives spi_done and
// spi_rx_data; a timestamp-based frame model predicts every output each cycle.
// Directed frames pin known values, then a randomized phase runs.

module tb_spi_frame_sequencer;

    localparam int CPS = 64;
    localparam int CS  = 3;
    localparam int TO  = 100;
    localparam logic [7:0] CMD = 8'h30;

    logic        clk = 1'b0;
    logic        nrst;
    logic        spi_cs;
    logic [23:0] spi_tx_data;
    logic [23:0] spi_rx_data;
    logic        spi_done;
    logic [15:0] dac_sample;
    logic        dac_valid;
    logic        dac_ready;
    logic [15:0] adc_sample;
    logic        adc_valid;
    logic        adc_ready;
    logic        status_clr;
    logic [3:0]  status;

    always #5 clk = ~clk;

    spi_frame_sequencer #(
        .CLK_PER_SAMPLE(CPS),
        .TX_WIDTH      (24),
        .RX_WIDTH      (24),
        .SAMPLE_WIDTH  (16),
        .TX_CMD        (CMD),
        .CS_LOW_CYCLES (CS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .spi_cs     (spi_cs),
        .spi_tx_data(spi_tx_data),
        .spi_rx_data(spi_rx_data),
        .spi_done   (spi_done),
        .dac_sample (dac_sample),
        .dac_valid  (dac_valid),
        .dac_ready  (dac_ready),
        .adc_sample (adc_sample),
        .adc_valid  (adc_valid),
        .adc_ready  (adc_ready),
        .status_clr (status_clr),
        .status     (status)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int          e = 0;        // edge counter
    int          phase;        // position within the frame period
    bit          busy;         // a frame is in flight
    int          L, low_e, high_e;
    logic [15:0] hold;
    bit          pending;
    logic [23:0] exp_tx;
    logic [15:0] exp_as;
    bit          exp_av;
    logic [3:0]  exp_st;
    bit          exp_cs, exp_dr;
    int          caps = 0;
    int          tos  = 0;
    bit          mvalid = 0;

    task automatic model_step();
        bit tick, launch, miss, under, over, cap, tmo, load;
        e++;
        if (!nrst) begin
            phase = 0; busy = 0; hold = 16'h0; pending = 0;
            exp_tx = {CMD, 16'h0000}; exp_as = 16'h0; exp_av = 0; exp_st = 4'h0;
            exp_cs = 1; exp_dr = 1; mvalid = 1;
            return;
        end
        tick  = (phase == CPS - 1);
        phase = tick ? 0 : phase + 1;
        cap = 0; tmo = 0;
        // Frame progress: controller must go busy, then idle; capture two edges later.
        if (busy && e > L + CS) begin
            if (high_e < 0) begin
`ifdef SEQ_TIMEOUT_EN
                if (e - (L + CS) == TO) tmo = 1;
`endif
                if (!tmo) begin
                    if (low_e < 0) begin
                        if (!spi_done) low_e = e;
                    end else if (spi_done) begin
                        high_e = e;
                    end
                end
            end else if (e == high_e + 2) begin
                cap = 1;
            end
        end
        launch = tick && !busy && spi_done;
        miss   = tick && !launch;
        under  = launch && !pending;
        load   = dac_valid && !pending;
        if (launch) begin
            exp_tx = {CMD, hold};
            busy = 1; L = e; low_e = -1; high_e = -1;
        end
        if (load) hold = dac_sample;
        pending = load ? 1'b1 : (launch ? 1'b0 : pending);
        over = 0;
        if (cap) begin
            over   = exp_av && !adc_ready;
            exp_as = spi_rx_data[15:0];
            exp_av = 1;
            busy   = 0;
            caps++;
        end else if (exp_av && adc_ready) begin
            exp_av = 0;
        end
        if (tmo) begin
            busy = 0;
            tos++;
        end
        exp_st = (status_clr ? 4'h0 : exp_st) | {tmo, miss, over, under};
        exp_cs = !(busy && (e - L) < CS);
        exp_dr = !pending;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every cycle once the model has seen a reset edge.
    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            chk("cyc_spi_cs", spi_cs, exp_cs);
            chk("cyc_spi_tx_data", spi_tx_data, exp_tx);
            chk("cyc_dac_ready", dac_ready, exp_dr);
            chk("cyc_adc_valid", adc_valid, exp_av);
            chk("cyc_adc_sample", adc_sample, exp_as);
            chk("cyc_status", status, exp_st);
        end
    end

    // ---------------- SPI controller model ----------------
    logic [23:0] rxq[$];
    bit          ctl_hang = 0;
    bit          ctl_long = 0;

    initial begin
        int xlen;
        spi_done    = 1'b1;
        spi_rx_data = 24'h0;
        forever begin
            step();
            if (spi_cs === 1'b0 && nrst === 1'b1) begin
                spi_done = 1'b0;
                if (ctl_hang) xlen = 2 * CPS + 10;
                else if (ctl_long && $urandom_range(0, 7) == 0) xlen = $urandom_range(CS + 1, 100);
                else xlen = $urandom_range(CS + 1, 30);
                repeat (xlen) step();
                if (rxq.size() > 0) spi_rx_data = rxq.pop_front();
                else spi_rx_data = $urandom;
                spi_done = 1'b1;
            end
        end
    end

    task automatic wait_caps(input int target, input string name);
        int n = 0;
        while (caps < target && n < 600) begin
            step();
            n++;
        end
        chk(name, caps >= target, 1);
    endtask

    task automatic dac_push(input logic [15:0] v);
        dac_valid  = 1'b1;
        dac_sample = v;
        step();
        dac_valid  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int c0;
        nrst       = 1'b0;
        dac_valid  = 1'b0;
        dac_sample = 16'h0;
        adc_ready  = 1'b0;
        status_clr = 1'b0;
        rxq.push_back(24'h001234);
        rxq.push_back(24'h00ABCD);
        rxq.push_back(24'h001111);
        rxq.push_back(24'h002222);
        rxq.push_back(24'h003333);
        repeat (3) step();
        nrst = 1'b1;
        chk("rst_spi_cs", spi_cs, 1);
        chk("rst_tx", spi_tx_data, 24'h300000);
        chk("rst_adc_valid", adc_valid, 0);
        chk("rst_status", status, 4'b0000);
        chk("rst_dac_ready", dac_ready, 1);

        // Frame 1: sample accepted before the tick.
        dac_push(16'hA5C3);
        wait_caps(1, "wait_f1");
        chk("f1_tx", spi_tx_data, 24'h30A5C3);
        chk("f1_adc_sample", adc_sample, 16'h1234);
        chk("f1_adc_valid", adc_valid, 1);
        chk("f1_status", status, 4'b0000);
        adc_ready = 1'b1;
        step();
        adc_ready = 1'b0;
        chk("f1_ack", adc_valid, 0);

        // Frame 2: no new sample -> retransmit and underrun.
        wait_caps(2, "wait_f2");
        chk("f2_tx_repeat", spi_tx_data, 24'h30A5C3);
        chk("f2_status", status, 4'b0001);
        chk("f2_adc_sample", adc_sample, 16'hABCD);

        // Frames 3 and 4 with adc_ready held low -> overrun.
        status_clr = 1'b1;
        dac_push(16'h0F0F);
        status_clr = 1'b0;
        wait_caps(3, "wait_f3");
        dac_push(16'h7777);
        wait_caps(4, "wait_f4");
        chk("f4_adc_sample", adc_sample, 16'h2222);
        chk("f4_status", status, 4'b0010);
        chk("f4_adc_valid", adc_valid, 1);

        // Frame 5: adc_ready pulsed exactly in CAPTURE -> no overrun.
        status_clr = 1'b1;
        dac_push(16'h1357);
        status_clr = 1'b0;
        n = 0;
        while (!(busy && high_e >= 0) && n < 600) begin
            step();
            n++;
        end
        chk("wait_f5_done", busy && high_e >= 0, 1);
        step();
        adc_ready = 1'b1;
        step();
        adc_ready = 1'b0;
        chk("f5_adc_sample", adc_sample, 16'h3333);
        chk("f5_adc_valid", adc_valid, 1);
        chk("f5_status", status, 4'b0000);

        // Controller stuck busy for two frame periods.
        status_clr = 1'b1;
        adc_ready  = 1'b1;
        dac_push(16'h2468);
        status_clr = 1'b0;
        ctl_hang   = 1;
        n = 0;
        while (spi_done && n < 200) begin
            step();
            n++;
        end
        ctl_hang = 0;
`ifdef SEQ_TIMEOUT_EN
        n = 0;
        while (tos < 1 && n < 400) begin
            step();
            n++;
        end
        chk("hang_timeout_seen", tos >= 1, 1);
        chk("hang_status3", status[3], 1);
        chk("hang_cs_idle", spi_cs, 1);
        n = 0;
        while (status[2] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("hang_status2", status[2], 1);
`else
        wait_caps(6, "wait_hang_capture");
        chk("hang_status2", status[2], 1);
        chk("hang_status3", status[3], 0);
`endif

        // Reset pulsed while waiting for the transfer to end.
        n = 0;
        while (!(busy && low_e >= 0 && high_e < 0) && n < 400) begin
            step();
            n++;
        end
        chk("wait_wait_end", busy && low_e >= 0 && high_e < 0, 1);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("rstmid_spi_cs", spi_cs, 1);
        chk("rstmid_adc_valid", adc_valid, 0);
        chk("rstmid_status", status, 4'b0000);
        chk("rstmid_tx", spi_tx_data, 24'h300000);
        adc_ready = 1'b0;
        c0 = caps;
        wait_caps(c0 + 1, "rstmid_next_frame");
        chk("rstmid_next_valid", adc_valid, 1);

        // Randomized traffic; the per-cycle compare does the checking.
        ctl_long = 1;
        for (int i = 0; i < 3000; i++) begin
            dac_valid  = ($urandom_range(0, 3) != 0);
            dac_sample = 16'($urandom);
            adc_ready  = ($urandom_range(0, 1) != 0);
            status_clr = ($urandom_range(0, 63) == 0);
            nrst       = ($urandom_range(0, 499) != 0);
            step();
        end
        nrst       = 1'b1;
        dac_valid  = 1'b0;
        status_clr = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_frame_sequencer.md
SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

Interface
- Parameters (name, default, meaning):
  - REQ-001 CLK_PER_SAMPLE, 1000: clk cycles per audio frame period (>= 4*FRAME_MIN, where FRAME_MIN is the longest SPI transfer in clk cycles).
  - REQ-002 TX_WIDTH, 24: width of the SPI transmit word.
  - REQ-003 RX_WIDTH, 24: width of the SPI receive word.
  - REQ-004 SAMPLE_WIDTH, 16: audio sample width (<= TX_WIDTH, <= RX_WIDTH).
  - REQ-005 TX_CMD, 8'h30: constant header placed in spi_tx_data[TX_WIDTH-1:SAMPLE_WIDTH].
  - REQ-006 CS_LOW_CYCLES, 2: cycles spi_cs is held low per frame launch (>= 2).
  - REQ-007 TIMEOUT_CYCLES, 4096: watchdog limit, used only when SEQ_TIMEOUT_EN is defined.
- Ports (name, direction, width, meaning):
  - REQ-008 clk, in, 1: clock.
  - REQ-009 nrst, in, 1: reset, synchronous, active-low.
  - REQ-010 spi_cs, out, 1: frame start strobe to the SPI controller; active-low.
  - REQ-011 spi_tx_data, out, TX_WIDTH: word to transmit.
  - REQ-012 spi_rx_data, in, RX_WIDTH: word received by the controller.
  - REQ-013 spi_done, in, 1: controller idle; high = idle.
  - REQ-014 dac_sample, in, SAMPLE_WIDTH: next outgoing sample.
  - REQ-015 dac_valid / dac_ready, in / out, 1 each: valid/ready handshake for dac_sample.
  - REQ-016 adc_sample, out, SAMPLE_WIDTH: last captured sample.
  - REQ-017 adc_valid / adc_ready, out / in, 1 each: valid/ready handshake for adc_sample.
  - REQ-018 status_clr, in, 1: clears all sticky status bits.
  - REQ-019 status, out, 4: sticky flags {timeout, miss, overrun, underrun}.

Function
- REQ-020 Frame tick: free-running counter 0..CLK_PER_SAMPLE-1; tick asserts for one cycle when count == CLK_PER_SAMPLE-1, then count wraps to 0.
- REQ-021 States: IDLE, CS_LOW, WAIT_START, WAIT_END, SETTLE, CAPTURE.
  - IDLE -> CS_LOW on tick & spi_done.
  - CS_LOW -> WAIT_START after CS_LOW_CYCLES cycles.
  - WAIT_START -> WAIT_END when spi_done == 0.
  - WAIT_END -> SETTLE when spi_done == 1.
  - SETTLE -> CAPTURE after one cycle.
  - CAPTURE -> IDLE after one cycle.
- REQ-022 spi_cs is 0 only in CS_LOW; it is 1 in all other states.
- REQ-023 At launch (the tick cycle taken in IDLE), spi_tx_data is registered as {TX_CMD, dac_hold}; it is held constant until the next launch.
- REQ-024 dac_hold is loaded on dac_valid & dac_ready; dac_ready = ~dac_pending; dac_pending sets on a load and clears at launch.
- REQ-025 At launch with dac_pending == 0, the previous dac_hold is retransmitted and status[0] (underrun) is set.
- REQ-026 In CAPTURE, adc_sample <= spi_rx_data[SAMPLE_WIDTH-1:0] and adc_valid <= 1; adc_valid clears on adc_valid & adc_ready.
- REQ-027 In CAPTURE with adc_valid == 1 & adc_ready == 0, adc_sample is overwritten, adc_valid stays 1, and status[1] (overrun) is set.
- REQ-028 In CAPTURE with adc_ready == 1 in the same cycle, the old sample is accepted, the new sample is loaded, adc_valid stays 1, and no overrun is flagged.
- REQ-029 A tick while the state is not IDLE, or in IDLE with spi_done == 0, launches no frame and sets status[2] (miss); the next launch waits for the following tick.
- REQ-030 Launch-to-capture latency is CS_LOW_CYCLES + (controller transfer time) + 2 cycles.
- REQ-031 status_clr clears the flags at the next clock edge; a set condition in the same cycle takes priority over the clear.

Reset
- REQ-032 While nrst == 0 at a clk edge: state = IDLE, sample counter = 0, spi_cs = 1, spi_tx_data = {TX_CMD, 0}, dac_hold = 0, dac_pending = 0, adc_sample = 0, adc_valid = 0, status = 0.
- REQ-033 Reset in any state aborts the frame; no partial sample is presented; spi_cs returns to 1 on the reset edge.

Configuration
- REQ-034 With SEQ_TIMEOUT_EN defined, a watchdog counter runs in WAIT_START and WAIT_END; on reaching TIMEOUT_CYCLES the FSM goes to IDLE, sets status[3], and does not assert adc_valid.
- REQ-035 Without SEQ_TIMEOUT_EN, no watchdog logic is compiled, the FSM waits indefinitely, and status[3] is tied to 0.

Verification
- REQ-036 CLK_PER_SAMPLE=64, dac_sample=16'hA5C3 accepted before tick; model returns rx 24'h00_1234 -> spi_tx_data=24'h30A5C3, adc_sample=16'h1234, adc_valid=1.
- REQ-037 No dac_valid before second tick -> spi_tx_data repeats 16'hA5C3, status=4'b0001.
- REQ-038 adc_ready held 0 across two frames (rx 1111 then 2222) -> adc_sample=16'h2222, status[1]=1; adc_ready pulse in CAPTURE -> no overrun.
- REQ-039 Model keeps spi_done=0 for 2*CLK_PER_SAMPLE -> status[2]=1, no new launch until done=1 and a tick; with SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100 -> status[3]=1 after 100 cycles, FSM in IDLE.
- REQ-040 nrst pulsed low during WAIT_END -> spi_cs=1, adc_valid=0, status=0 the cycle after reset; a normal frame follows.
